// File: rtl/ad9276_spi_init_seq.sv
// Drives the AD9276 SPI master core's register port: selects the slave and sets up control.
// Streams ROM commands gated on TRDY, then waits for TMT. Optional poll timeout: AD9276_SPI_SEQ_TIMEOUT_EN.
module ad9276_spi_init_seq #(
  parameter int          CMD_AW   = 8,
  parameter int          POLL_MAX = 4095,
  parameter logic [31:0] SS_MASK  = 32'h1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CMD_AW-1:0] num_cmds,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CMD_AW-1:0] cmd_addr,
  input  logic [23:0]       cmd_data,
  output logic              spi_select,
  output logic [2:0]        spi_addr,
  output logic [31:0]       spi_wdata,
  output logic              spi_write_n,
  output logic              spi_read_n,
  input  logic [31:0]       spi_rdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SS_WR,
    S_CTRL_WR,
    S_FETCH,
    S_POLL_TRDY,
    S_TX_WR,
    S_POLL_TMT,
    S_CLR_ST,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        wr_n;
    logic        rd_n;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    sel: 1'b0, addr: 3'd0, wdata: 32'd0,
    wr_n: 1'b1, rd_n: 1'b1
  };

  state_t            st;
  state_t            nxt;
  bus_t              bus;
  logic [1:0]        ph;
  logic [2:0]        stat;
  logic [23:0]       hold;
  logic [CMD_AW-1:0] idx;
  logic [CMD_AW-1:0] idx_nx;
  logic [CMD_AW-1:0] ncmd;
  logic              err_set;
  logic              to_hit;

  // Bus drive for the first asserted cycle of each access state
  function automatic bus_t bus_for(state_t s, logic [23:0] h);
    bus_t b;
    b = BUS_IDLE;
    case (s)
      S_SS_WR: begin
        b.sel = 1'b1; b.addr = 3'd5;
        b.wdata = SS_MASK; b.wr_n = 1'b0;
      end
      S_CTRL_WR, S_CLR_ST: begin
        b.sel = 1'b1;
        b.addr = (s == S_CTRL_WR) ? 3'd3 : 3'd2;
        b.wr_n = 1'b0;
      end
      S_TX_WR: begin
        b.sel = 1'b1; b.addr = 3'd1;
        b.wdata = {8'h00, h}; b.wr_n = 1'b0;
      end
      S_POLL_TRDY, S_POLL_TMT: begin
        b.sel = 1'b1; b.addr = 3'd2;
        b.rd_n = 1'b0;
      end
      default: b = BUS_IDLE;
    endcase
    return b;
  endfunction

  assign spi_select  = bus.sel;
  assign spi_addr    = bus.addr;
  assign spi_wdata   = bus.wdata;
  assign spi_write_n = bus.wr_n;
  assign spi_read_n  = bus.rd_n;

`ifdef AD9276_SPI_SEQ_TIMEOUT_EN
  logic [31:0] poll_cnt;
  assign to_hit = (poll_cnt >= 32'(POLL_MAX - 1));
`else
  assign to_hit = 1'b0;
`endif

  // stat = {TRDY, TMT, TOE} captured from the last read
  always_comb begin
    nxt     = st;
    err_set = 1'b0;
    idx_nx  = idx;
    case (st)
      S_SS_WR:   nxt = S_CTRL_WR;
      S_CTRL_WR: nxt = (ncmd == '0) ? S_POLL_TMT : S_FETCH;
      S_POLL_TRDY: begin
        if (stat[0] || (!stat[2] && to_hit)) begin
          err_set = 1'b1;
          nxt     = S_CLR_ST;
        end else if (stat[2]) begin
          nxt = S_TX_WR;
        end
      end
      S_TX_WR: begin
        idx_nx = idx + 1'b1;
        nxt    = (idx_nx == ncmd) ? S_POLL_TMT : S_FETCH;
      end
      S_POLL_TMT: begin
        if (stat[0] || (!stat[1] && to_hit)) begin
          err_set = 1'b1;
          nxt     = S_CLR_ST;
        end else if (stat[1]) begin
          nxt = S_CLR_ST;
        end
      end
      S_CLR_ST: nxt = error ? S_IDLE : S_DONE;
      default:  nxt = st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= S_IDLE;
      bus      <= BUS_IDLE;
      ph       <= 2'd0;
      stat     <= 3'd0;
      hold     <= 24'd0;
      idx      <= '0;
      ncmd     <= '0;
      cmd_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef AD9276_SPI_SEQ_TIMEOUT_EN
      poll_cnt <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            idx   <= '0;
            ncmd  <= num_cmds;
            busy  <= 1'b1;
            ph    <= 2'd0;
            st    <= S_SS_WR;
            bus   <= bus_for(S_SS_WR, hold);
          end
        end
        S_FETCH: begin
          if (ph == 2'd0) begin
            ph <= 2'd1;
          end else begin
            hold <= cmd_data;
            ph   <= 2'd0;
            st   <= S_POLL_TRDY;
            bus  <= bus_for(S_POLL_TRDY, cmd_data);
`ifdef AD9276_SPI_SEQ_TIMEOUT_EN
            poll_cnt <= 32'd0;
`endif
          end
        end
        S_DONE: st <= S_IDLE;
        default: begin
          // Two asserted cycles, then one idle cycle that also decides
          if (ph == 2'd0) begin
            ph <= 2'd1;
          end else if (ph == 2'd1) begin
            stat <= spi_rdata[6:4];
            bus  <= BUS_IDLE;
            ph   <= 2'd2;
          end else begin
            ph  <= 2'd0;
            st  <= nxt;
            idx <= idx_nx;
            bus <= bus_for(nxt, hold);
            if (nxt == S_FETCH)
              cmd_addr <= idx_nx;
            if (err_set)
              error <= 1'b1;
            if (st == S_CLR_ST) begin
              busy <= 1'b0;
              done <= !error;
            end
`ifdef AD9276_SPI_SEQ_TIMEOUT_EN
            poll_cnt <= (nxt == st) ? poll_cnt + 32'd1 : 32'd0;
`endif
          end
        end
      endcase
    end
  end

endmodule
